// File: rtl/serial_sub_using_fa_if.sv
// serial_sub_using_fa_if: request/result bundle for the bit-serial subtractor
interface serial_sub_using_fa_if #(parameter int WIDTH = 8);
  logic start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic busy;
  logic done;
  logic [WIDTH-1:0] diff;
  logic borr;
  logic ovf;
  modport master(output start, a, b, input busy, done, diff, borr, ovf);
  modport slave(input start, a, b, output busy, done, diff, borr, ovf);
endinterface

// File: rtl/serial_sub_using_fa.sv
// serial_sub_using_fa: bit-serial a-b via one full adder (a+~b+1), LSB first
module serial_sub_using_fa #(
  parameter int WIDTH = 8
) (
  input logic clk,
  input logic rst,
  serial_sub_using_fa_if.slave bus
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;
  logic [WIDTH-1:0] sa, sb, diff_q, wide;
  logic [WIDTH-2:0] acc;
  logic [CW-1:0] cnt;
  logic carry, borr_q, ovf_q, s, co, nb, last, load;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb begin
    load = bus.start && (state == IDLE || state == DONE);
    last = cnt == LAST;
    state_nxt = state == SHIFT ? (last ? DONE : SHIFT) : (load ? SHIFT : IDLE);
    bus.busy = state == SHIFT;
    bus.done = state == DONE;
  end
  assign nb = ~sb[0];
  assign s = sa[0] ^ nb ^ carry;
  assign co = (sa[0] & nb) | (sa[0] & carry) | (nb & carry);
  assign wide = {s, acc};
  always_ff @(posedge clk) begin
    if (rst) begin
      sa <= '0;
      sb <= '0;
      acc <= '0;
      cnt <= '0;
      carry <= 1'b0;
      diff_q <= '0;
      borr_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (load) begin
      sa <= bus.a;
      sb <= bus.b;
      carry <= 1'b1;
      cnt <= '0;
    end else if (state == SHIFT) begin
      sa <= sa >> 1;
      sb <= sb >> 1;
      acc <= wide[WIDTH-1:1];
      carry <= co;
      cnt <= cnt + 1'b1;
      if (last) begin
        diff_q <= wide;
        borr_q <= ~co;
        ovf_q <= carry ^ co;
      end
    end
  end
  assign bus.diff = diff_q;
  assign bus.borr = borr_q;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_serial_sub_using_fa.sv
// tb_serial_sub_using_fa: directed and random checks against an arithmetic model
module tb_serial_sub_using_fa;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  serial_sub_using_fa_if #(.WIDTH(W)) bus();
  serial_sub_using_fa #(.WIDTH(W)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    int sd;
    logic [W-1:0] d;
    sd = int'($signed(x)) - int'($signed(y));
    d = x - y;
    return {(sd < -(2 ** (W - 1)) || sd > 2 ** (W - 1) - 1), x < y, d};
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic shift_phase(input string tag);
    for (int i = 0; i < W; i++) begin
      chk({tag, "_busy"}, 32'(bus.busy), 1);
      chk({tag, "_nodone"}, 32'(bus.done), 0);
      step();
    end
  endtask
  task automatic check_done(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W+1:0] r;
    r = ref_sub(x, y);
    chk({tag, "_done"}, 32'(bus.done), 1);
    chk({tag, "_dbusy"}, 32'(bus.busy), 0);
    chk({tag, "_diff"}, 32'(bus.diff), 32'(r[W-1:0]));
    chk({tag, "_borr"}, 32'(bus.borr), 32'(r[W]));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(r[W+1]));
  endtask
  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    bus.a = x;
    bus.b = y;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    bus.a = ~x;
    bus.b = ~y;
    shift_phase(tag);
    check_done(tag, x, y);
    step();
    chk({tag, "_idle"}, 32'({bus.busy, bus.done}), 0);
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    step();
    step();
    chk("rst_out", 32'({bus.busy, bus.done, bus.borr, bus.ovf}), 0);
    chk("rst_diff", 32'(bus.diff), 0);
    rst = 1'b0;
    step();
    do_op("t05_03", 8'h05, 8'h03);
    chk("t05_03_hold", 32'(bus.diff), 32'h02);
    do_op("t03_05", 8'h03, 8'h05);
    do_op("t00_00", 8'h00, 8'h00);
    do_op("t80_01", 8'h80, 8'h01);
    do_op("t7f_ff", 8'h7F, 8'hFF);
    bus.a = 8'h10;
    bus.b = 8'h01;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    step();
    step();
    bus.a = 8'hFF;
    bus.b = 8'h00;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < W - 4; i++) begin
      chk("ign_busy", 32'(bus.busy), 1);
      step();
    end
    check_done("ign", 8'h10, 8'h01);
    for (int i = 0; i < W + 2; i++) begin
      step();
      chk("ign_quiet", 32'({bus.busy, bus.done}), 0);
    end
    bus.a = 8'h0A;
    bus.b = 8'h04;
    bus.start = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      shift_phase("b2b");
      check_done("b2b", 8'h0A, 8'h04);
      step();
    end
    chk("b2b_rebusy", 32'(bus.busy), 1);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) step();
    chk("b2b_final", 32'(bus.done), 1);
    step();
    bus.a = 8'hAA;
    bus.b = 8'h55;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_out", 32'({bus.busy, bus.done, bus.borr, bus.ovf}), 0);
    chk("mrst_diff", 32'(bus.diff), 0);
    step();
    chk("mrst_idle", 32'({bus.busy, bus.done}), 0);
    do_op("taa_55", 8'hAA, 8'h55);
    for (int n = 0; n < 30; n++) begin
      logic [W-1:0] x, y;
      x = W'($urandom);
      y = (n % 7 == 0) ? x : W'($urandom);
      do_op("rnd", x, y);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_sub_using_fa.md
Name: serial_sub_using_fa

Overview:
Bit-serial N-bit subtractor that computes a − b, LSB first, one bit per clock. Each bit goes through a single full-adder cell as a + ~b + carry, with carry preset to 1, so the final borrow is ~carry. This is the sequential, adder-based counterpart to the combinational adder/subtractor cells in the arithmetic library. It is used where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits (≥2).

Ports:
clk    input   1      rising-edge clock
rst    input   1      synchronous reset, active-high
start  input   1      request; sampled only in IDLE or DONE
a      input   WIDTH  minuend, captured on accepted start
b      input   WIDTH  subtrahend, captured on accepted start
busy   output  1      high while bits are being processed
done   output  1      one-cycle pulse when result is valid
diff   output  WIDTH  a − b mod 2^WIDTH
borr   output  1      unsigned borrow out (1 when a < b unsigned)
ovf    output  1      signed (two's complement) overflow

Behaviour:
- Clocking and reset:
  - One clock domain (clk).
  - Reset is synchronous and active-high (rst).
  - While rst is high at a clock edge, the FSM goes to IDLE and busy, done, diff, borr, ovf and all internal registers become 0.
  - rst has priority over everything, including mid-operation; the partial result is discarded.
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: busy=0, done=0. start=1 → load shift regs sa=a, sb=b; carry=1; bit counter=0; go to SHIFT.
  - SHIFT: busy=1, done=0. Each cycle:
    - s = sa[0] ^ ~sb[0] ^ carry
    - carry ← majority(sa[0], ~sb[0], carry)
    - s is shifted into the diff register from the MSB side
    - sa and sb shift right
    - counter increments
    - On the cycle processing bit WIDTH−1, capture the sign bits and the carry-in to the MSB for ovf; after that edge go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle. Then go to IDLE, unless start=1 in this cycle: then reload the operands and go directly to SHIFT.
- Outputs at DONE:
  - borr = ~carry_final.
  - ovf = carry_into_msb XOR carry_out_of_msb. This equals (a[MSB] ≠ b[MSB]) && (diff[MSB] ≠ a[MSB]).
- Output holding:
  - diff, borr and ovf are updated only at the transition into DONE.
  - They hold their values until the next transition into DONE or until reset. A new start does not clear them.
  - During SHIFT, the visible diff is the previous result; the working shift register is internal.
- Latency: with start accepted at edge k, SHIFT occupies cycles k+1 … k+WIDTH and done is high during cycle k+WIDTH+1. Back-to-back throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored and not queued. Operands a and b may change freely after the accepting edge.
- start held high continuously gives back-to-back operations through the DONE→SHIFT path with no IDLE cycle.
- Equal operands give diff=0, borr=0, ovf=0.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, pulse start → busy for 8 cycles, done on the 9th cycle after the start edge, diff=0x02, borr=0, ovf=0.
- a=0x03, b=0x05 → diff=0xFE, borr=1, ovf=0. Then a=0x00, b=0x00 → diff=0x00, borr=0, ovf=0.
- a=0x80, b=0x01 → diff=0x7F, borr=0, ovf=1. Then a=0x7F, b=0xFF → diff=0x80, borr=1, ovf=1.
- a=0x10, b=0x01 accepted; 3 cycles later start=1 with a=0xFF, b=0x00 → ignored: result diff=0x0F, single done pulse, no second operation.
- start held high with a=0x0A, b=0x04 → done pulses every 9 cycles, diff=0x06 each time, busy re-asserts the cycle after each done.
- Start a=0xAA, b=0x55; assert rst for 1 cycle at SHIFT bit 4 → next cycle busy=0, done=0, diff=0, borr=0, ovf=0, state IDLE. A subsequent start with a=0xAA, b=0x55 yields diff=0x55, borr=0, ovf=1.
